// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches words from instruction memory,
// holds the current instruction for the decode controller and computes the
// next PC on the controller's write_pc strobe.
// Optional feature macro: HALT_DETECT_EN (opcode 6'b111111 stops fetching).
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [31:0]       imem_rdata_i,
  input  logic              imem_valid_i,
  output logic [31:0]       instr_o,
  output logic [5:0]        opecode_o,
  output logic [5:0]        funct_o,
  output logic              instr_valid_o,
  output logic [ADDR_W-1:0] pc_o,
  input  logic              write_pc_i,
  input  logic [1:0]        cp_type_i,
  input  logic              enbranch_i,
  input  logic              write_lr_i,
  input  logic [ADDR_W-1:0] jr_target_i,
  output logic [ADDR_W-1:0] link_addr_o,
  output logic              halted_o
);

`ifdef HALT_DETECT_EN
  typedef enum logic [1:0] {StFetch, StExec, StHalt} state_e;
`else
  typedef enum logic [1:0] {StFetch, StExec} state_e;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] link_q, link_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] imm_sext;
  logic [ADDR_W-1:0] next_pc;

  // Sign-extends (or truncates, for narrow PCs) the 16-bit branch offset.
  assign pc_inc   = pc_q + ADDR_W'(1);
  assign imm_sext = ADDR_W'($signed(instr_q[15:0]));

  // Next-PC selection; all arithmetic wraps modulo 2^ADDR_W.
  always_comb begin
    next_pc = pc_inc;
    case (cp_type_i)
      2'b00:   next_pc = pc_inc;
      2'b01:   next_pc = jr_target_i;
      2'b10:   next_pc = instr_q[ADDR_W-1:0];
      default: next_pc = enbranch_i ? (pc_inc + imm_sext) : pc_inc;
    endcase
  end

  // FSM next-state plus PC, instruction and link register updates.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    link_d  = link_q;
    case (state_q)
      StFetch: begin
        if (imem_valid_i) begin
          instr_d = imem_rdata_i;
          state_d = StExec;
        end
      end
      StExec: begin
        if (write_pc_i) begin
`ifdef HALT_DETECT_EN
          if (instr_q[31:26] == 6'b111111) begin
            state_d = StHalt;
          end else
`endif
          begin
            pc_d    = next_pc;
            state_d = StFetch;
            if (write_lr_i) begin
              link_d = pc_inc;
            end
          end
        end
      end
`ifdef HALT_DETECT_EN
      StHalt: state_d = StHalt;
`endif
      default: state_d = StFetch;
    endcase
  end

  // State registers; reset also aborts any fetch in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      link_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      link_q  <= link_d;
    end
  end

  assign imem_req_o    = (state_q == StFetch);
  assign imem_addr_o   = pc_q;
  assign instr_o       = instr_q;
  assign opecode_o     = instr_q[31:26];
  assign funct_o       = instr_q[5:0];
  assign instr_valid_o = (state_q == StExec);
  assign pc_o          = pc_q;
  assign link_addr_o   = link_q;
`ifdef HALT_DETECT_EN
  assign halted_o      = (state_q == StHalt);
`else
  assign halted_o      = 1'b0;
`endif

endmodule
